// File: rtl/wallace_mult_arbiter_if.sv
// Requester/response bundle for the shared Wallace multiplier arbiter.
// slave is the arbiter side; master is the requester/consumer side.
interface wallace_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [15:0]       ops_done;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy, ops_done
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy, ops_done
  );
endinterface

// File: rtl/wallace_mult_arbiter.sv
// Round-robin sequencer sharing one combinational 8x8 Wallace multiplier among
// NREQ requesters; operands are held for SETTLE_CYCLES clocks before capture.

module wallace (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);
  logic [15:0] pp_s [8];
  logic [15:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s, s3_s, c3_s;
  logic [15:0] s4_s, c4_s, s5_s, c5_s;

  function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    return {1'b0, x} + {1'b0, y} + {4'd0, cin};
  endfunction

  // Partial-product rows, row i shifted left by i
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = {8'd0, a & {8{b[i]}}} << i;
    end
  end

  // Four levels of 3:2 compression reduce eight rows to two (8-6-4-3-2)
  always_comb begin
    s0_s = csa_sum  (pp_s[0], pp_s[1], pp_s[2]);
    c0_s = csa_carry(pp_s[0], pp_s[1], pp_s[2]);
    s1_s = csa_sum  (pp_s[3], pp_s[4], pp_s[5]);
    c1_s = csa_carry(pp_s[3], pp_s[4], pp_s[5]);
    s2_s = csa_sum  (s0_s, c0_s, s1_s);
    c2_s = csa_carry(s0_s, c0_s, s1_s);
    s3_s = csa_sum  (c1_s, pp_s[6], pp_s[7]);
    c3_s = csa_carry(c1_s, pp_s[6], pp_s[7]);
    s4_s = csa_sum  (s2_s, c2_s, s3_s);
    c4_s = csa_carry(s2_s, c2_s, s3_s);
    s5_s = csa_sum  (s4_s, c4_s, c3_s);
    c5_s = csa_carry(s4_s, c4_s, c3_s);
  end

  // Carry-select final adder in 4-bit blocks; the product never exceeds 16 bits
  always_comb begin
    logic       carry_v;
    logic [4:0] lo_v;
    logic [4:0] hi_v;
    carry_v = 1'b0;
    product = 16'd0;
    for (int blk = 0; blk < 4; blk++) begin
      lo_v = add4(s5_s[4*blk +: 4], c5_s[4*blk +: 4], 1'b0);
      hi_v = add4(s5_s[4*blk +: 4], c5_s[4*blk +: 4], 1'b1);
      if (carry_v) begin
        product[4*blk +: 4] = hi_v[3:0];
        carry_v             = hi_v[4];
      end else begin
        product[4*blk +: 4] = lo_v[3:0];
        carry_v             = lo_v[4];
      end
    end
  end
endmodule

module wallace_mult_arbiter #(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDW           = $clog2(NREQ)
) (
  input logic                clk,
  input logic                rst_n,
  wallace_mult_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  state_t          state_r, state_nxt_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      op_a_r, op_b_r;
  logic [IDW-1:0]  id_r;
  logic            rsp_valid_r;
  logic [15:0]     rsp_data_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [15:0]     ops_done_r;

  logic            found_s;
  logic [IDW-1:0]  win_s;
  logic [NREQ-1:0] grant_s;
  logic [NREQ-1:0] req_ready_s;
  logic [7:0]      sel_a_s, sel_b_s;
  logic            accept_s;
  logic            rsp_fire_s;
  logic [15:0]     product_s;

  // The multiplier only ever sees the held operand registers
  wallace u_wallace (
    .a       (op_a_r),
    .b       (op_b_r),
    .product (product_s)
  );

  // Round-robin search from rr_ptr upward, plus operand mux for the winner
  always_comb begin
    logic [IDW:0] sum_v;
    logic [IDW-1:0] idx_v;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_v = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      if (sum_v >= (IDW+1)'(NREQ)) begin
        sum_v = sum_v - (IDW+1)'(NREQ);
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[IDW-1:0];
      if (!found_s && bus.req_valid[idx_v]) begin
        found_s = 1'b1;
        win_s   = idx_v;
      end else begin
        found_s = found_s;
      end
    end
    sel_a_s = 8'd0;
    sel_b_s = 8'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_s == IDW'(k)) begin
        sel_a_s = bus.req_a[8*k +: 8];
        sel_b_s = bus.req_b[8*k +: 8];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  // Grant is visible only in IDLE and never while reset is asserted
  always_comb begin
    grant_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    if (found_s && (state_r == IDLE) && rst_n) begin
      req_ready_s = grant_s;
      accept_s    = 1'b1;
    end else begin
      req_ready_s = '0;
      accept_s    = 1'b0;
    end
    rsp_fire_s = rsp_valid_r && bus.rsp_ready;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = WAIT;
        else          state_nxt_s = IDLE;
      end
      WAIT: begin
        if (cnt_r == '0) state_nxt_s = RESP;
        else             state_nxt_s = WAIT;
      end
      RESP: begin
        if (rsp_fire_s) state_nxt_s = IDLE;
        else            state_nxt_s = RESP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, settle countdown, product capture and response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= '0;
      cnt_r       <= '0;
      op_a_r      <= 8'd0;
      op_b_r      <= 8'd0;
      id_r        <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'd0;
      rsp_id_r    <= '0;
      ops_done_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_a_r <= sel_a_s;
            op_b_r <= sel_b_s;
            id_r   <= win_s;
            cnt_r  <= CNT_INIT;
            if (win_s == IDW'(NREQ - 1)) rr_ptr_r <= '0;
            else                         rr_ptr_r <= win_s + 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - 1'b1;
          end else begin
            rsp_data_r  <= product_s;
            rsp_id_r    <= id_r;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_fire_s) begin
            rsp_valid_r <= 1'b0;
            ops_done_r  <= ops_done_r + 16'd1;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.ops_done  = ops_done_r;
endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Directed bench for wallace_mult_arbiter: vector table plus hand-written
// round-robin, backpressure and mid-operation reset sequences.
module tb_wallace_mult_arbiter;
  localparam int NREQ   = 4;
  localparam int SETTLE = 2;
  localparam int IDW    = 2;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  wallace_mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  wallace_mult_arbiter #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*id +: 8] = a;
    bus.req_b[8*id +: 8] = b;
    bus.req_valid[id]    = 1'b1;
  endtask

  // Wait for a grant, check it, let the accept edge pass; ends on a negedge in WAIT
  task automatic wait_grant(input int id, input bit drop);
    int n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
    check("grant_id", 32'(bus.req_ready), 32'(1 << id));
    @(posedge clk);
    @(negedge clk);
    if (drop) bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input logic [15:0] p);
    int lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(SETTLE));
    check("rsp_id", 32'(bus.rsp_id), 32'(id));
    check("rsp_data", 32'(bus.rsp_data), 32'(p));
    check("busy_resp", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    exp_ops++;
    check("ops_done", 32'(bus.ops_done), 32'(exp_ops));
    check("rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs [6];
    logic [7:0]  rr_a [4];
    logic [7:0]  rr_b [4];
    logic [15:0] rr_p [4];
    int n;

    vecs[0] = '{id: 1, a: 8'd13,  b: 8'd11,  p: 16'd143};
    vecs[1] = '{id: 0, a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[2] = '{id: 2, a: 8'd0,   b: 8'd200, p: 16'd0};
    vecs[3] = '{id: 1, a: 8'd128, b: 8'd2,   p: 16'd256};
    vecs[4] = '{id: 2, a: 8'd1,   b: 8'd255, p: 16'd255};
    vecs[5] = '{id: 3, a: 8'd37,  b: 8'd19,  p: 16'd703};
    rr_a = '{8'd10, 8'd17, 8'd24, 8'd31};
    rr_b = '{8'd3,  8'd8,  8'd13, 8'd18};
    rr_p = '{16'd30, 16'd136, 16'd312, 16'd558};

    // Reset state, with every requester asking
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ops_done", 32'(bus.ops_done), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single-requester operations (last one leaves rr_ptr at 0)
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b);
      wait_grant(vecs[i].id, 1'b1);
      wait_rsp(vecs[i].id, vecs[i].p);
    end

    // All four requesters valid continuously: grants 0,1,2,3,0
    for (int i = 0; i < 4; i++) issue(i, rr_a[i], rr_b[i]);
    for (int g = 0; g < 5; g++) begin
      wait_grant(g % 4, 1'b0);
      wait_rsp(g % 4, rr_p[g % 4]);
    end
    bus.req_valid = '0;
    @(negedge clk);

    // Pointer after granting 2 favours 3 over 0
    issue(2, 8'd7, 8'd9);
    wait_grant(2, 1'b1);
    wait_rsp(2, 16'd63);
    issue(0, 8'd5, 8'd6);
    issue(3, 8'd12, 8'd12);
    wait_grant(3, 1'b1);
    wait_rsp(3, 16'd144);
    wait_grant(0, 1'b1);
    wait_rsp(0, 16'd30);

    // Backpressure in RESP with another requester pending
    bus.rsp_ready = 1'b0;
    issue(1, 8'd200, 8'd100);
    issue(0, 8'd3, 8'd3);
    wait_grant(1, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", 32'(n), 32'(SETTLE));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(bus.rsp_data), 32'd20000);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.rsp_ready    = 1'b1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    exp_ops++;
    check("bp_ops_done", 32'(bus.ops_done), 32'(exp_ops));
    check("bp_rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("bp_idle", 32'(bus.busy), 32'd0);
    check("bp_single_hs", 32'(bus.ops_done), 32'(exp_ops));

    // Reset pulsed during WAIT aborts the operation
    issue(2, 8'd50, 8'd50);
    wait_grant(2, 1'b1);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_ops_done", 32'(bus.ops_done), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ops = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    issue(0, 8'd9, 8'd9);
    issue(3, 8'd4, 8'd4);
    wait_grant(0, 1'b1);
    wait_rsp(0, 16'd81);
    wait_grant(3, 1'b1);
    wait_rsp(3, 16'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wallace_mult_arbiter.md
# wallace_mult_arbiter

Round-robin arbiter and sequencer that shares one instance of the team's 8x8 Wallace multiplier (`wallace`, gate-delay modelled, carry-select final adder) among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and holds the operands stable in registers for SETTLE_CYCLES clocks while the combinational tree settles. It then captures the 16-bit product and returns it with the requester's index over a valid/ready response channel. It sits between the requester ports and the shared multiplier datapath.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- SETTLE_CYCLES, 2, clocks operands are held before the product is captured; must be ≥1
- IDW, $clog2(NREQ), width of the requester index
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset; asynchronous and active-low
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant; at most one bit high
- req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- req_b  input  8*NREQ  operand B; same packing as req_a
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_data  output  16  product a*b, unsigned
- rsp_id  output  IDW  index of the requester that owns rsp_data
- busy  output  1  high in any state other than IDLE
- ops_done  output  16  count of completed responses; wraps 65535→0

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready is the one-hot of the winner, combinational from req_valid and rr_ptr. It is all-zero if no request is pending, in any state other than IDLE, or while rst_n=0.
  - On an edge where req_valid[g]&req_ready[g]=1 (the accept):
    - op_a←req_a[g], op_b←req_b[g], id←g
    - cnt←SETTLE_CYCLES-1
    - rr_ptr←(g+1) mod NREQ
    - go to WAIT
- WAIT
  - Multiplier inputs are driven only from op_a and op_b, so they are stable for the whole state.
  - If cnt≠0: cnt←cnt-1.
  - If cnt=0: rsp_data←product, rsp_id←id, rsp_valid←1, go to RESP.
- RESP
  - rsp_valid, rsp_data and rsp_id are held constant until rsp_valid&rsp_ready=1 at an edge.
  - On that edge: rsp_valid←0, ops_done←ops_done+1, go to IDLE.
- rsp_data and rsp_id keep their last values after the handshake. Consumers qualify them with rsp_valid.
- Requesters must hold req_valid and their operands until granted. A requester may deassert req_valid before it is granted; arbitration then simply re-evaluates.
- Only one operation is in flight. No new request is accepted in WAIT or RESP.
- Arithmetic is unsigned 8x8→16 with no truncation. The result is exactly the multiplier's 16-bit output.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, rr_ptr=0, cnt=0
  - op_a=op_b=0, id=0
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - ops_done=0, busy=0, req_ready=0
- Latency: accept at edge E0 → rsp_valid high after edge E0+SETTLE_CYCLES.
- Minimum issue interval is SETTLE_CYCLES+2 clocks: accept, SETTLE_CYCLES cycles in WAIT, response handshake, then return to IDLE. Back-to-back accept is possible on the first cycle back in IDLE.
- SETTLE_CYCLES=1: capture occurs on the first edge after the accept.
- rsp_ready held low keeps the FSM in RESP indefinitely, with outputs frozen. rsp_ready high during IDLE or WAIT has no effect.
- A request and a response handshake never occur on the same edge, because the two happen in disjoint states.
- Reset asserted mid-operation (WAIT or RESP) aborts the operation. No response is produced, ops_done is not incremented, and all state returns to its reset value immediately.
- rr_ptr wraps from NREQ-1 to 0.

## Test plan
- Single request: requester 1 sends a=13, b=11 with rsp_ready=1 and SETTLE_CYCLES=2 → req_ready=4'b0010 in the same cycle; rsp_valid two edges after the accept, with rsp_data=143, rsp_id=1, and ops_done=1 after the handshake.
- All four requesters valid continuously with distinct operands → grants occur in order 0,1,2,3,0; req_ready is never more than one-hot; each rsp_id matches its operands' product.
- Round-robin pointer: grant requester 2, then raise requests on 0 and 3 together → 3 is granted before 0.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP → rsp_valid stays 1, rsp_data and rsp_id are unchanged, req_ready stays 0 and busy stays 1; releasing rsp_ready completes exactly one handshake.
- Corners: 255×255 → 65025; 0×200 → 0; 128×2 → 256; 1×255 → 255.
- Reset mid-WAIT: rst_n pulsed low for one cycle during WAIT → rsp_valid=0, ops_done=0, rr_ptr=0; the next request completes normally.
